// File: rtl/rx_ocp_master.sv
// rx_ocp_master: converts PCIe TLP beats (header slices and data beats) into
// single-beat OCP commands: one RD command per read TLP, one WR command per
// data DW of a write TLP.
// Ports:
//   rx_clk, rx_reset          clock, async active-high reset
//   rx_data/rx_valid/rx_ready AXI beat from the PCIe core (taken on valid&&ready)
//   ocp_reg_ctl               slice select for the current beat (H1/H2/DATA3/DATA4)
//   optype                    {has data, 4DW header} of the captured TLP
//   ocp_ready                 room for another 2-DW data beat
//   MCmd/MAddr/MData/MByteEn/MBurstLength, SCmdAccept   OCP master port
//   hdr_overrun               pulse when an H1 beat arrives while busy
module rx_ocp_master #(
   parameter int unsigned DATA_W = 64
) (
   input  logic              rx_clk,
   input  logic              rx_reset,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_valid,
   input  logic              rx_ready,
   input  logic [2:0]        ocp_reg_ctl,
   output logic [1:0]        optype,
   output logic              ocp_ready,
   output logic [2:0]        MCmd,
   output logic [63:0]       MAddr,
   output logic [31:0]       MData,
   output logic [3:0]        MByteEn,
   output logic [10:0]       MBurstLength,
   input  logic              SCmdAccept,
   output logic              hdr_overrun
);

   localparam int unsigned ADDR_W  = 64;
   localparam int unsigned DW_W    = 32;
   localparam int unsigned LEN_W   = 11;
   localparam int unsigned DEPTH   = 4;

   localparam logic [2:0] CTL_H1 = 3'b001;
   localparam logic [2:0] CTL_H2 = 3'b010;
   localparam logic [2:0] CTL_D3 = 3'b011;
   localparam logic [2:0] CTL_D4 = 3'b100;

   localparam logic [2:0] CMD_IDLE = 3'b000;
   localparam logic [2:0] CMD_WR   = 3'b001;
   localparam logic [2:0] CMD_RD   = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         optype_q, optype_d;
   logic [LEN_W-1:0]   len_q, len_d;        // total DWs (1..1024)
   logic [LEN_W-1:0]   remain_q, remain_d;  // DWs not yet issued on OCP
   logic [LEN_W-1:0]   pend_q, pend_d;      // DWs not yet pushed into the FIFO
   logic [3:0]         fbe_q, fbe_d, lbe_q, lbe_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DW_W-1:0]    mem_q [DEPTH];
   logic [DW_W-1:0]    mem_d [DEPTH];
   logic [1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [2:0]         cnt_q, cnt_d;
   logic [2:0]         mcmd_q, mcmd_d;
   logic [ADDR_W-1:0]  maddr_q, maddr_d;
   logic [DW_W-1:0]    mdata_q, mdata_d;
   logic [3:0]         mbe_q, mbe_d;
   logic [LEN_W-1:0]   mbl_q, mbl_d;
   logic               ovr_q, ovr_d;
   logic               ordy_q, ordy_d;

   logic               take;
   logic [1:0]         n_push;
   logic               pop;
   logic [DW_W-1:0]    push0, push1;

   assign take = rx_valid && rx_ready;

   // Header capture, FIFO bookkeeping, FSM and next OCP outputs
   always_comb begin
      state_d  = state_q;
      optype_d = optype_q;
      len_d    = len_q;
      remain_d = remain_q;
      pend_d   = pend_q;
      fbe_d    = fbe_q;
      lbe_d    = lbe_q;
      addr_d   = addr_q;
      mem_d    = mem_q;
      ovr_d    = 1'b0;
      n_push   = 2'd0;
      pop      = 1'b0;
      push0    = rx_data[31:0];
      push1    = rx_data[63:32];

      if (take) begin
         case (ocp_reg_ctl)
            CTL_H1: begin
               if (state_q == ST_IDLE) begin
                  optype_d = rx_data[30:29];
                  fbe_d    = rx_data[35:32];
                  lbe_d    = rx_data[39:36];
                  len_d    = (rx_data[9:0] == 10'd0) ? 11'd1024 : {1'b0, rx_data[9:0]};
                  remain_d = len_d;
                  pend_d   = len_d;
               end else begin
                  ovr_d = 1'b1;
               end
            end
            CTL_H2: begin
               if (state_q == ST_IDLE) begin
                  if (optype_q[0]) begin
                     addr_d = {rx_data[31:0], rx_data[63:34], 2'b00};
                  end else begin
                     addr_d = {32'h0, rx_data[31:2], 2'b00};
                     // 3DW write: the upper half of H2 already carries DW0
                     if (optype_q[1] && pend_q != 11'd0) begin
                        n_push = 2'd1;
                        push0  = rx_data[63:32];
                     end
                  end
                  state_d = optype_q[1] ? ST_WR : ST_RD;
               end
            end
            CTL_D3, CTL_D4: begin
               // Surplus DWs past the TLP length are dropped
               if (state_q == ST_WR && pend_q != 11'd0)
                  n_push = (pend_q >= 11'd2) ? 2'd2 : 2'd1;
            end
            default: ;
         endcase
      end

      if (n_push != 2'd0)
         pend_d = pend_q - 11'(n_push);

      if (state_q == ST_RD && mcmd_q == CMD_RD && SCmdAccept)
         state_d = ST_IDLE;

      if (state_q == ST_WR && mcmd_q == CMD_WR && SCmdAccept) begin
         pop      = 1'b1;
         addr_d   = addr_q + 64'd4;
         remain_d = remain_q - 11'd1;
         if (remain_d == 11'd0)
            state_d = ST_IDLE;
      end

      if (n_push != 2'd0)
         mem_d[wr_ptr_q] = push0;
      if (n_push == 2'd2)
         mem_d[wr_ptr_q + 2'd1] = push1;

      wr_ptr_d = wr_ptr_q + n_push;
      rd_ptr_d = rd_ptr_q + 2'(pop);
      cnt_d    = cnt_q + 3'(n_push) - 3'(pop);

      // Outputs are computed from next state so they are registered yet
      // appear one cycle after H2 (RD) or the first push (WR).
      mcmd_d  = CMD_IDLE;
      maddr_d = '0;
      mdata_d = '0;
      mbe_d   = 4'h0;
      mbl_d   = '0;
      if (state_d == ST_RD) begin
         mcmd_d  = CMD_RD;
         maddr_d = addr_d;
         mbe_d   = fbe_d;
         mbl_d   = len_d;
      end else if (state_d == ST_WR && cnt_d != 3'd0) begin
         mcmd_d  = CMD_WR;
         maddr_d = addr_d;
         mdata_d = mem_d[rd_ptr_d];
         mbl_d   = 11'd1;
         if (remain_d == len_d)
            mbe_d = fbe_d;
         else if (remain_d == 11'd1)
            mbe_d = lbe_d;
         else
            mbe_d = 4'hF;
      end

      ordy_d = (cnt_d <= 3'd2) && (state_d != ST_RD);
   end

   // State and output registers
   always_ff @(posedge rx_clk or posedge rx_reset) begin
      if (rx_reset) begin
         state_q  <= ST_IDLE;
         optype_q <= 2'b00;
         len_q    <= '0;
         remain_q <= '0;
         pend_q   <= '0;
         fbe_q    <= 4'h0;
         lbe_q    <= 4'h0;
         addr_q   <= '0;
         for (int i = 0; i < int'(DEPTH); i++)
            mem_q[i] <= '0;
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
         cnt_q    <= 3'd0;
         mcmd_q   <= CMD_IDLE;
         maddr_q  <= '0;
         mdata_q  <= '0;
         mbe_q    <= 4'h0;
         mbl_q    <= '0;
         ovr_q    <= 1'b0;
         ordy_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         optype_q <= optype_d;
         len_q    <= len_d;
         remain_q <= remain_d;
         pend_q   <= pend_d;
         fbe_q    <= fbe_d;
         lbe_q    <= lbe_d;
         addr_q   <= addr_d;
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         mcmd_q   <= mcmd_d;
         maddr_q  <= maddr_d;
         mdata_q  <= mdata_d;
         mbe_q    <= mbe_d;
         mbl_q    <= mbl_d;
         ovr_q    <= ovr_d;
         ordy_q   <= ordy_d;
      end
   end

   assign optype       = optype_q;
   assign ocp_ready    = ordy_q;
   assign MCmd         = mcmd_q;
   assign MAddr        = maddr_q;
   assign MData        = mdata_q;
   assign MByteEn      = mbe_q;
   assign MBurstLength = mbl_q;
   assign hdr_overrun  = ovr_q;

endmodule

// File: tb/tb_rx_ocp_master.sv
// Testbench for rx_ocp_master: random and directed TLPs, expected OCP
// commands queued per TLP and checked by an independent monitor.
module tb_rx_ocp_master;

   localparam logic [2:0] C_H1 = 3'd1;
   localparam logic [2:0] C_H2 = 3'd2;
   localparam logic [2:0] C_D3 = 3'd3;
   localparam logic [2:0] C_D4 = 3'd4;

   logic        rx_clk = 1'b0;
   logic        rx_reset;
   logic [63:0] rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [2:0]  ocp_reg_ctl;
   logic [1:0]  optype;
   logic        ocp_ready;
   logic [2:0]  MCmd;
   logic [63:0] MAddr;
   logic [31:0] MData;
   logic [3:0]  MByteEn;
   logic [10:0] MBurstLength;
   logic        SCmdAccept;
   logic        hdr_overrun;

   rx_ocp_master #(.DATA_W(64)) dut (
      .rx_clk(rx_clk), .rx_reset(rx_reset), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .ocp_reg_ctl(ocp_reg_ctl),
      .optype(optype), .ocp_ready(ocp_ready), .MCmd(MCmd), .MAddr(MAddr),
      .MData(MData), .MByteEn(MByteEn), .MBurstLength(MBurstLength),
      .SCmdAccept(SCmdAccept), .hdr_overrun(hdr_overrun)
   );

   always #5 rx_clk = ~rx_clk;

   typedef struct {
      logic [2:0]  cmd;
      logic [63:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic [10:0] bl;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] fixed_dw[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          ovr_cnt = 0;
   int          wr_acc  = 0;
   bit          stall   = 1'b0;
   int          acc_pct = 100;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Slave acceptance: random, or held low while stall is set
   initial begin
      SCmdAccept = 1'b0;
      forever begin
         @(posedge rx_clk);
         #2;
         SCmdAccept = !stall && ($urandom_range(99) < 32'(acc_pct));
      end
   end

   // Monitor: checks every accepted command against the scoreboard and
   // checks that a pending command is held until accepted.
   logic [2:0]  p_cmd;
   logic [63:0] p_addr;
   logic [31:0] p_data;
   logic [3:0]  p_be;
   bit          have_prev = 1'b0;
   exp_t        me;

   always @(negedge rx_clk) begin
      if (rx_reset) begin
         have_prev = 1'b0;
      end else begin
         if (hdr_overrun) ovr_cnt++;
         if (have_prev) begin
            chk("hold_cmd",  64'(MCmd),    64'(p_cmd));
            chk("hold_addr", MAddr,        p_addr);
            chk("hold_data", 64'(MData),   64'(p_data));
            chk("hold_be",   64'(MByteEn), 64'(p_be));
            have_prev = 1'b0;
         end
         if (MCmd != 3'd0) begin
            if (SCmdAccept) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_cmd: got cmd %0d addr 0x%0h, expected none", MCmd, MAddr);
               end else begin
                  me = exp_q.pop_front();
                  chk("cmd",  64'(MCmd),         64'(me.cmd));
                  chk("addr", MAddr,             me.addr);
                  chk("be",   64'(MByteEn),      64'(me.be));
                  chk("bl",   64'(MBurstLength), 64'(me.bl));
                  if (me.cmd == 3'd1) begin
                     chk("data", 64'(MData), 64'(me.data));
                     wr_acc++;
                  end
               end
            end else begin
               p_cmd = MCmd; p_addr = MAddr; p_data = MData; p_be = MByteEn;
               have_prev = 1'b1;
            end
         end
      end
   end

   // One beat; data beats wait for room in the block
   task automatic beat(input logic [2:0] ctl, input logic [63:0] d, input bit is_data);
      int n;
      n = 0;
      if (is_data) begin
         while (!ocp_ready && n < 5000) begin
            @(posedge rx_clk); #1;
            n++;
         end
         if (!ocp_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: ocp_ready 0 for %0d cycles, expected 1", n);
         end
      end
      rx_valid = 1'b1; rx_ready = 1'b1; ocp_reg_ctl = ctl; rx_data = d;
      @(posedge rx_clk); #1;
      rx_valid = 1'b0; rx_ready = 1'b0; ocp_reg_ctl = 3'd0;
   endtask

   // Full TLP: queue the expected OCP commands, then send the beats
   task automatic send_tlp(input bit wr, input bit dw4, input int n, input logic [3:0] fbe,
                           input logic [3:0] lbe, input logic [63:0] addr, input bit ovr);
      logic [31:0] dws[$];
      logic [63:0] h1, h2, a;
      exp_t e;
      int idx;
      a = dw4 ? {addr[63:2], 2'b00} : {32'h0, addr[31:2], 2'b00};
      for (int i = 0; i < n; i++)
         dws.push_back((fixed_dw.size() != 0) ? fixed_dw.pop_front() : $urandom);
      if (wr) begin
         for (int i = 0; i < n; i++) begin
            e.cmd  = 3'd1;
            e.addr = a + 64'(4 * i);
            e.data = dws[i];
            e.be   = (i == 0) ? fbe : ((i == n - 1) ? lbe : 4'hF);
            e.bl   = 11'd1;
            exp_q.push_back(e);
         end
      end else begin
         e.cmd = 3'd2; e.addr = a; e.data = 32'h0; e.be = fbe; e.bl = 11'(n);
         exp_q.push_back(e);
      end
      h1 = {$urandom, $urandom};
      h1[30:29] = {wr, dw4};
      h1[9:0]   = 10'(n);
      h1[35:32] = fbe;
      h1[39:36] = lbe;
      beat(C_H1, h1, 1'b0);
      chk("optype", 64'(optype), 64'({wr, dw4}));
      if (dw4) h2 = {addr[31:2], 2'($urandom), addr[63:32]};
      else     h2 = {(wr ? dws[0] : 32'($urandom)), addr[31:2], 2'($urandom)};
      beat(C_H2, h2, 1'b0);
      if (ovr) beat(C_H1, {$urandom, $urandom}, 1'b0);
      if (wr) begin
         idx = dw4 ? 0 : 1;
         while (idx < n) begin
            beat(dw4 ? C_D4 : C_D3, {((idx + 1 < n) ? dws[idx + 1] : 32'($urandom)), dws[idx]}, 1'b1);
            idx += 2;
         end
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 20000) begin
         @(posedge rx_clk);
         n++;
      end
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL done_timeout: %0d commands outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(posedge rx_clk);
      #1;
      chk("idle_after", 64'(MCmd), 64'd0);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_mcmd",  64'(MCmd),         64'd0);
      chk("rst_maddr", MAddr,             64'd0);
      chk("rst_mdata", 64'(MData),        64'd0);
      chk("rst_mbe",   64'(MByteEn),      64'd0);
      chk("rst_mbl",   64'(MBurstLength), 64'd0);
      chk("rst_optype",64'(optype),       64'd0);
      chk("rst_ovr",   64'(hdr_overrun),  64'd0);
      chk("rst_ready", 64'(ocp_ready),    64'd1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   bit seen_not_ready;
   int w0, o0;

   initial begin
      rx_reset = 1'b1; rx_valid = 1'b0; rx_ready = 1'b0;
      ocp_reg_ctl = 3'd0; rx_data = 64'd0;
      repeat (3) @(posedge rx_clk);
      #1;
      chk_reset_outputs();
      rx_reset = 1'b0;
      @(posedge rx_clk); #1;

      // 3DW read held under no-accept
      stall = 1'b1;
      send_tlp(1'b0, 1'b0, 4, 4'hF, 4'h0, 64'h1000, 1'b0);
      repeat (3) begin
         @(negedge rx_clk);
         chk("rd_held", 64'(MCmd), 64'd2);
      end
      stall = 1'b0;
      wait_done();

      // 3DW write A,B,C; then a 2-DW one where the second DW of its beat is surplus
      fixed_dw = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
      send_tlp(1'b1, 1'b0, 3, 4'hE, 4'h3, 64'h2000, 1'b0);
      wait_done();
      send_tlp(1'b1, 1'b0, 2, 4'h7, 4'h1, 64'h3000, 1'b0);
      wait_done();

      // 4DW write, 64-bit address wrap, single-DW write
      send_tlp(1'b1, 1'b1, 2, 4'hF, 4'hF, 64'h1_8000_0000, 1'b0);
      wait_done();
      send_tlp(1'b1, 1'b1, 4, 4'hC, 4'h3, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
      wait_done();
      send_tlp(1'b1, 1'b0, 1, 4'h5, 4'hA, 64'h4000, 1'b0);
      wait_done();

      // H1 while writing
      o0 = ovr_cnt;
      send_tlp(1'b1, 1'b0, 5, 4'h8, 4'h1, 64'h5000, 1'b1);
      wait_done();
      chk("overrun_pulses", 64'(ovr_cnt - o0), 64'd1);

      // 1024-DW write with a 10-cycle accept stall
      acc_pct = 100;
      w0 = wr_acc;
      seen_not_ready = 1'b0;
      fork
         send_tlp(1'b1, 1'b1, 1024, 4'h3, 4'hC, 64'h0000_0002_0000_0100, 1'b0);
         begin
            repeat (20) @(posedge rx_clk);
            stall = 1'b1;
            repeat (10) begin
               @(negedge rx_clk);
               if (!ocp_ready) seen_not_ready = 1'b1;
            end
            stall = 1'b0;
         end
      join
      wait_done();
      chk("bp_ready_dropped", 64'(seen_not_ready), 64'd1);
      chk("bp_write_count", 64'(wr_acc - w0), 64'd1024);

      // Reset with 3 DWs buffered, then a clean TLP
      stall = 1'b1;
      beat(C_H1, 64'h0000_00F3_4000_0006, 1'b0);
      beat(C_H2, {32'hDEAD_0000, 32'h0000_6000}, 1'b0);
      beat(C_D3, {32'hDEAD_0002, 32'hDEAD_0001}, 1'b1);
      repeat (2) @(posedge rx_clk);
      #1;
      chk("pre_rst_cmd", 64'(MCmd), 64'd1);
      rx_reset = 1'b1;
      #1;
      chk_reset_outputs();
      exp_q.delete();
      repeat (2) @(posedge rx_clk);
      #1;
      rx_reset = 1'b0;
      chk("post_rst_cmd", 64'(MCmd), 64'd0);
      stall = 1'b0;
      @(posedge rx_clk); #1;
      chk("post_rst_cmd2", 64'(MCmd), 64'd0);
      send_tlp(1'b1, 1'b0, 3, 4'h9, 4'h6, 64'h7000, 1'b0);
      wait_done();

      // Random TLPs
      for (int t = 0; t < 24; t++) begin
         bit wr, dw4;
         int n;
         logic [63:0] a;
         wr  = 1'($urandom);
         dw4 = 1'($urandom);
         n   = ($urandom_range(3) == 0) ? int'($urandom_range(13, 40)) : int'($urandom_range(1, 12));
         a   = dw4 ? {$urandom, $urandom} : {32'h0, $urandom};
         acc_pct = int'($urandom_range(20, 100));
         send_tlp(wr, dw4, n, 4'($urandom), 4'($urandom), a, 1'b0);
         wait_done();
      end

      chk("overrun_total", 64'(ovr_cnt), 64'd1);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
